// File: rtl/pipe_tx_scrambler.sv
// pipe_tx_scrambler: PCIe TX lane scrambler (Gen1/2 16-bit LFSR, Gen3+ 23-bit LFSR) with a registered valid/ready output stage.
module pipe_tx_scrambler #(
  parameter logic [15:0] GEN12_SEED = 16'hFFFF,
  parameter int BLOCK_SYMBOLS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        turnOff,
  input  logic [2:0]  GEN,
  input  logic [5:0]  PIPEWIDTH,
  input  logic [23:0] seedValue,
  input  logic        inValid,
  output logic        inReady,
  input  logic [1:0]  inSyncHeader,
  input  logic [31:0] inData,
  input  logic [3:0]  inDataK,
  output logic        scramblerDataValid,
  input  logic        scramblerReady,
  output logic [1:0]  scramblerSyncHeader,
  output logic [31:0] scramblerData,
  output logic [3:0]  scramblerDataK,
  output logic        blockStart
);
  localparam int CW = $clog2(BLOCK_SYMBOLS + 4);

  logic [CW-1:0] cnt, sum, cnt_d;
  logic [1:0]    hdr_q, hdr_eff;
  logic          skp_q, eieos_q, run;
  logic [15:0]   l12_q, l12_d;
  logic [22:0]   l3_q, l3_d;
  logic [31:0]   data_d;
  logic [7:0]    sym;
  logic [23:0]   r12;
  logic [30:0]   r3;
  logic [2:0]    n;
  logic          gen3, first, data_blk, skp_blk, eieos_blk, accept;
  logic          unused_seed_msb;

  // Eight serial shifts of the Galois LFSR; returns {keystream byte, next state}.
  function automatic logic [23:0] step12(input logic [15:0] s);
    logic [7:0] k;
    for (int b = 0; b < 8; b++) begin
      k[b] = s[15];
      s = {s[14:0], s[15]} ^ {10'b0, {3{s[15]}}, 3'b0};
    end
    return {k, s};
  endfunction

  function automatic logic [30:0] step3(input logic [22:0] s);
    logic [7:0] k;
    for (int b = 0; b < 8; b++) begin
      k[b] = s[22];
      s = {s[21:0], s[22]} ^ ({23{s[22]}} & 23'h210124);
    end
    return {k, s};
  endfunction

  assign unused_seed_msb = seedValue[23];
  assign gen3 = GEN >= 3'd3;
  assign n = PIPEWIDTH == 6'd16 ? 3'd2 : PIPEWIDTH == 6'd32 ? 3'd4 : 3'd1;
  assign first = cnt == '0;
  assign hdr_eff = first ? inSyncHeader : hdr_q;
  assign data_blk = hdr_eff == 2'b01;
  // Ordered-set type is decided by symbol 0, which is always byte0 of the block's first beat.
  assign skp_blk = first ? !data_blk && inData[7:0] == 8'hAA : skp_q;
  assign eieos_blk = first ? !data_blk && inData[7:0] == 8'h00 : eieos_q;
  assign inReady = run && (!scramblerDataValid || scramblerReady);
  assign accept = inValid && inReady;
  assign sum = cnt + CW'(n);
  assign cnt_d = sum >= CW'(BLOCK_SYMBOLS) ? sum - CW'(BLOCK_SYMBOLS) : sum;

  always_comb begin
    l12_d = l12_q;
    l3_d = l3_q;
    data_d = '0;
    sym = '0;
    r12 = '0;
    r3 = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(n)) begin
        sym = inData[8*i +: 8];
        r12 = step12(l12_d);
        r3 = step3(l3_d);
        if (gen3) begin
          data_d[8*i +: 8] = sym ^ (data_blk && !turnOff ? r3[30:23] : 8'h00);
          l3_d = skp_blk ? l3_d : r3[22:0];
          l3_d = eieos_blk && cnt + CW'(i) == CW'(BLOCK_SYMBOLS - 1) ? seedValue[22:0] : l3_d;
        end else begin
          data_d[8*i +: 8] = sym ^ (!inDataK[i] && !turnOff ? r12[23:16] : 8'h00);
          l12_d = inDataK[i] && sym == 8'hBC ? GEN12_SEED :
                  inDataK[i] && sym == 8'h1C ? l12_d : r12[15:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run <= 1'b0;
      scramblerDataValid <= 1'b0;
      scramblerSyncHeader <= '0;
      scramblerData <= '0;
      scramblerDataK <= '0;
      blockStart <= 1'b0;
      l12_q <= GEN12_SEED;
      l3_q <= seedValue[22:0];
      cnt <= '0;
      hdr_q <= '0;
      skp_q <= 1'b0;
      eieos_q <= 1'b0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        scramblerDataValid <= 1'b1;
        scramblerData <= data_d;
        scramblerDataK <= inDataK;
        scramblerSyncHeader <= gen3 ? hdr_eff : 2'b00;
        blockStart <= gen3 && first;
        l12_q <= l12_d;
        l3_q <= l3_d;
        cnt <= gen3 ? cnt_d : '0;
        hdr_q <= hdr_eff;
        skp_q <= skp_blk;
        eieos_q <= eieos_blk;
      end else if (scramblerReady) begin
        scramblerDataValid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pipe_tx_scrambler.sv
// tb_pipe_tx_scrambler: directed stimulus with a queue scoreboard for pipe_tx_scrambler.
module tb_pipe_tx_scrambler;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        turnOff = 1'b0;
  logic [2:0]  GEN = 3'd1;
  logic [5:0]  PIPEWIDTH = 6'd8;
  logic [23:0] seedValue = 24'h1DBFBC;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [1:0]  inSyncHeader = 2'b00;
  logic [31:0] inData = '0;
  logic [3:0]  inDataK = '0;
  logic        scramblerDataValid;
  logic        scramblerReady = 1'b1;
  logic [1:0]  scramblerSyncHeader;
  logic [31:0] scramblerData;
  logic [3:0]  scramblerDataK;
  logic        blockStart;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic [1:0]  h;
    logic        bs;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errs = 0;
  int outs = 0;
  logic [22:0] m3;

  pipe_tx_scrambler dut (
    .clk(clk), .reset(reset), .turnOff(turnOff), .GEN(GEN), .PIPEWIDTH(PIPEWIDTH),
    .seedValue(seedValue), .inValid(inValid), .inReady(inReady), .inSyncHeader(inSyncHeader),
    .inData(inData), .inDataK(inDataK), .scramblerDataValid(scramblerDataValid),
    .scramblerReady(scramblerReady), .scramblerSyncHeader(scramblerSyncHeader),
    .scramblerData(scramblerData), .scramblerDataK(scramblerDataK), .blockStart(blockStart)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Monitor samples just before the rising edge, where a valid&&ready transfer will happen.
  always @(negedge clk) begin
    #3;
    if (!reset && scramblerDataValid && scramblerReady) begin
      checks++;
      outs++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL out%0d: got unexpected data=%h, required no output", outs, scramblerData);
      end else begin
        e = q.pop_front();
        if (scramblerData !== e.d || scramblerDataK !== e.k || scramblerSyncHeader !== e.h || blockStart !== e.bs) begin
          errs++;
          $display("FAIL out%0d: got data=%h k=%h hdr=%b bs=%b, required data=%h k=%h hdr=%b bs=%b",
                   outs, scramblerData, scramblerDataK, scramblerSyncHeader, blockStart, e.d, e.k, e.h, e.bs);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic [1:0] h,
                      input logic [31:0] ed, input logic [1:0] eh, input logic ebs);
    int t = 0;
    q.push_back('{d: ed, k: k, h: eh, bs: ebs});
    inValid = 1'b1;
    inData = d;
    inDataK = k;
    inSyncHeader = h;
    #1;
    while (!inReady && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 100) begin
      checks++;
      errs++;
      $display("FAIL send_timeout: got inReady=0 for %0d cycles, required 1", t);
    end
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic s12(input logic [31:0] d, input logic [3:0] k, input logic [31:0] ed);
    send(d, k, 2'b00, ed, 2'b00, 1'b0);
  endtask

  task automatic next_key3(output logic [7:0] kb);
    for (int b = 0; b < 8; b++) begin
      kb[b] = m3[22];
      m3 = {m3[21:0], 1'b0} ^ (kb[b] ? 23'h210125 : 23'h0);
    end
  endtask

  task automatic g3_block(input logic [1:0] h, input logic [31:0] w0, input logic [31:0] w, input int nb);
    logic [31:0] d, x;
    logic [7:0] kb;
    logic is_data, skp, eie;
    is_data = h == 2'b01;
    skp = !is_data && w0[7:0] == 8'hAA;
    eie = !is_data && w0[7:0] == 8'h00;
    for (int b = 0; b < nb; b++) begin
      d = b == 0 ? w0 : w;
      x = d;
      for (int i = 0; i < 4; i++) begin
        if (!skp) begin
          next_key3(kb);
          if (is_data && !turnOff) x[8*i +: 8] = d[8*i +: 8] ^ kb;
        end
        if (eie && b * 4 + i == 15) m3 = seedValue[22:0];
      end
      send(d, 4'b0000, h, x, h, b == 0);
    end
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL %s_drain: got %0d outputs missing, required 0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic reset_dut(input string nm);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk({nm, "_rst_valid"}, 32'(scramblerDataValid), 32'd0);
    chk({nm, "_rst_data"}, scramblerData, 32'd0);
    chk({nm, "_rst_k"}, 32'(scramblerDataK), 32'd0);
    chk({nm, "_rst_hdr"}, 32'(scramblerSyncHeader), 32'd0);
    chk({nm, "_rst_bs"}, 32'(blockStart), 32'd0);
    chk({nm, "_rst_ready"}, 32'(inReady), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk({nm, "_ready_after_rst"}, 32'(inReady), 32'd1);
    m3 = seedValue[22:0];
  endtask

  initial begin
    // Gen1/2, width 8: COM then D00 with junk in the masked upper bytes
    reset_dut("g12w8");
    s12(32'h000000BC, 4'b0001, 32'h000000BC);
    s12(32'hA5A5A500, 4'b0000, 32'h000000FF);
    s12(32'h5A5A5A00, 4'b0000, 32'h00000017);
    s12(32'hFFFFFF00, 4'b0000, 32'h000000C0);
    s12(32'h12345600, 4'b0000, 32'h00000014);
    drain("g12w8");
    // Gen1/2, width 32
    PIPEWIDTH = 6'd32;
    reset_dut("g12w32");
    s12(32'h000000BC, 4'b0001, 32'hC017FFBC);
    s12(32'h00000000, 4'b0000, 32'h02E7B214);
    drain("g12w32");
    // SKP symbols leave the LFSR untouched
    PIPEWIDTH = 6'd8;
    reset_dut("skp");
    s12(32'h000000BC, 4'b0001, 32'h000000BC);
    s12(32'h0000001C, 4'b0001, 32'h0000001C);
    s12(32'h0000001C, 4'b0001, 32'h0000001C);
    s12(32'h0000001C, 4'b0001, 32'h0000001C);
    s12(32'h00000000, 4'b0000, 32'h000000FF);
    drain("skp");
    // Backpressure: output must hold while downstream stalls
    reset_dut("bp");
    scramblerReady = 1'b0;
    s12(32'h000000BC, 4'b0001, 32'h000000BC);
    for (int c = 0; c < 3; c++) begin
      chk("bp_inready", 32'(inReady), 32'd0);
      chk("bp_hold_data", scramblerData, 32'h000000BC);
      chk("bp_hold_valid", 32'(scramblerDataValid), 32'd1);
      @(negedge clk);
    end
    scramblerReady = 1'b1;
    s12(32'h00000000, 4'b0000, 32'h000000FF);
    s12(32'h00000000, 4'b0000, 32'h00000017);
    s12(32'h00000000, 4'b0000, 32'h000000C0);
    s12(32'h00000000, 4'b0000, 32'h00000014);
    drain("bp");
    // Gen3 width 32: data, SKP OS, data continuing the stream
    GEN = 3'd3;
    PIPEWIDTH = 6'd32;
    reset_dut("g3");
    g3_block(2'b01, 32'h0, 32'h0, 4);
    g3_block(2'b10, 32'hAAAAAAAA, 32'hAAAAAAAA, 4);
    g3_block(2'b01, 32'h0, 32'h0, 4);
    // EIEOS reloads the seed after its last symbol
    g3_block(2'b10, 32'hFF00FF00, 32'hFF00FF00, 4);
    g3_block(2'b01, 32'h0, 32'h0, 4);
    drain("g3");
    // Reset in the middle of a data block
    g3_block(2'b01, 32'h0, 32'h0, 2);
    drain("g3mid");
    reset_dut("g3mid");
    g3_block(2'b01, 32'h0, 32'h0, 4);
    drain("g3after");
    // turnOff bypasses data yet keeps the LFSR advancing
    turnOff = 1'b1;
    g3_block(2'b01, 32'h11223344, 32'h55667788, 4);
    turnOff = 1'b0;
    g3_block(2'b01, 32'h0, 32'h0, 4);
    drain("toff");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule

// File: doc/pipe_tx_scrambler.md
Name: pipe_tx_scrambler

Overview:
- Transmit-side scrambler for one PCIe lane. It sits between the TX link/framing logic and the PIPE TX data interface.
- It scrambles 8/16/32-bit PIPE symbols using the Gen1/2 16-bit LFSR (8b/10b K/D rules) or the Gen3+ 23-bit per-lane LFSR (128b/130b block rules).
- It tracks block position, handles COM/SKP/EIEOS/SKP-OS LFSR rules, and provides a registered valid/ready output stage.

Parameters:
- GEN12_SEED, 16'hFFFF, Gen1/2 LFSR initial and COM-reload value.
- BLOCK_SYMBOLS, 16, symbols per 128b/130b block.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- turnOff  in  1  1 = scrambling disabled; data bypassed unmodified; LFSR rules still apply.
- GEN  in  3  PCIe generation. <3 selects Gen1/2 mode, >=3 selects Gen3+ mode. Quasi-static; change only while reset is asserted.
- PIPEWIDTH  in  6  8, 16 or 32 (bits per beat). Quasi-static.
- seedValue  in  24  Gen3+ lane seed; bits [22:0] are used.
- inValid  in  1  input beat valid.
- inReady  out  1  input accepted when inValid && inReady.
- inSyncHeader  in  2  01 = data block, 10 = ordered-set block. Sampled on the first beat of a block.
- inData  in  32  symbols; byte0 = earliest symbol.
- inDataK  in  4  per-byte K flag (Gen1/2 only).
- scramblerDataValid  out  1  output beat valid.
- scramblerReady  in  1  downstream ready.
- scramblerSyncHeader  out  2  sync header of the current block, passed through.
- scramblerData  out  32  scrambled symbols; unused upper bytes are 0.
- scramblerDataK  out  4  inDataK passed through.
- blockStart  out  1  Gen3+: output beat holds symbol 0 of a block.

Behaviour:
- Reset (synchronous, high):
  - All outputs 0, except inReady=1 the cycle after reset deasserts.
  - Gen1/2 LFSR = GEN12_SEED; Gen3 LFSR = seedValue[22:0].
  - Symbol counter = 0; skpBlock = 0; eieosBlock = 0.
  - Reset mid-block drops the partial block; the next accepted beat is symbol 0.
- Handshake and latency:
  - inReady = !scramblerDataValid || scramblerReady.
  - An accepted beat is registered and appears on the outputs 1 cycle later.
  - Outputs hold stable while scramblerDataValid && !scramblerReady.
  - LFSR and counter advance only on accepted beats.
- Symbols per beat: n = PIPEWIDTH/8. Illegal PIPEWIDTH is treated as 8.
- Symbol processing: within a beat, symbols are processed byte0..byte(n-1) sequentially. Each processed symbol sees the LFSR state left by the previous symbol.
- Scrambling of one symbol:
  - Bit i (LSB first) is XORed with the LFSR output before the i-th of 8 shifts.
  - Gen1/2: Galois x^16+x^5+x^4+x^3+1, output bit lfsr[15].
  - Gen3+: x^23+x^21+x^16+x^8+x^5+x^2+1, output bit lfsr[22].
- Gen1/2 rules per symbol:
  - K && 8'hBC (COM): not scrambled; LFSR reloads GEN12_SEED after this symbol.
  - K && 8'h1C (SKP): not scrambled; no advance.
  - Other K: not scrambled; advance 8.
  - D: scrambled (unless turnOff); advance 8.
  - inSyncHeader is ignored; blockStart=0.
- Gen3+ rules:
  - Counter runs 0..15 and advances by n per accepted beat, wrapping to 0. Symbol 0 of a block starts at counter 0.
  - At counter 0, inSyncHeader is latched for the whole block.
  - Data block (01): every symbol scrambled; advance 8 per symbol.
  - Ordered-set block (10): symbols not scrambled.
    - Symbol 0 == 8'hAA (SKP OS): skpBlock=1 for the block; no LFSR advance for any symbol of it.
    - Symbol 0 == 8'h00 (EIEOS): advance per symbol; LFSR reloads seedValue after symbol 15.
    - Other OS: advance per symbol.
  - Invalid sync header (00/11): treated as an OS block for LFSR purposes; data passed unscrambled.
  - inDataK is ignored for the scrambling decision.
- turnOff=1: scramblerData equals the input bytes. LFSR/counter behaviour is unchanged, so re-enabling stays in sync.
- Width masking: bytes at index >= n are 0 on scramblerData.

Test Plan:
- Gen1/2 K/D, width 8: GEN=1, reset, beats K:BC then D:00 x4 → out BC, FF, 17, C0, 14, each 1 cycle after accept.
- Gen1/2 width 32: one beat {00,00,00,BC}, K=4'b0001 → scramblerData={C0,17,FF,BC}, scramblerDataK=0001. Next beat D:00 x4 → bytes 14,B2,E7,02.
- SKP no-advance, width 8: COM, SKP, SKP, SKP, D:00 → out BC,1C,1C,1C,FF.
- Backpressure: as the K/D case with scramblerReady=0 for 3 cycles after first output → inReady=0, output held at BC; then FF,17,C0,14 in order, no loss or duplication.
- Gen3 SKP OS, width 32, seed 0x1DBFBC:
  - Data block of 00s → scrambled LFSR stream.
  - Then an OS block with symbol0=AA → unscrambled, blockStart on its first beat.
  - Next data block continues the stream exactly where the first data block stopped.
- Reset mid-block / turnOff:
  - Gen3, assert reset after 2 beats of a data block → all outputs 0. The next block starts at counter 0 with the seed stream.
  - turnOff=1 → data = input, and the LFSR still advances (verified after turnOff drops).
